// File: rtl/cmd_link_responder.sv
// cmd_link_responder: 8N1 UART 3-byte command frame receiver and 1-byte response transmitter (CMD_GAP_TIMEOUT_EN adds inter-byte gap timeout)
module cmd_link_responder #(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);
    localparam int CW = $clog2(BAUD_DIV + 1);

    typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} fr_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    rx_state_t rx_state, rx_nxt;
    fr_state_t fr_state, fr_nxt;
    tx_state_t tx_state, tx_nxt;

    logic          rx_m, rx_s, rx_d, rx_fall, rx_tick, rx_rdy;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic [3:0]    rx_bit, tx_bit;
    logic [7:0]    rx_byte, cmd_sh, hi_sh;
    logic [9:0]    tx_sr;
    logic          gap_to, fr_done, tx_tick, tx_start;

    assign rx_fall = rx_d & ~rx_s;
    assign rx_tick = rx_state == RX_BUSY && rx_cnt == CW'(1);

    always_comb begin
        rx_nxt = rx_state;
        rx_nxt = (rx_state == RX_IDLE) ? (rx_fall ? RX_BUSY : RX_IDLE) :
                 (rx_tick && ((rx_bit == 4'd0 && rx_s) || rx_bit == 4'd9)) ? RX_IDLE : RX_BUSY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            {rx_m, rx_s, rx_d} <= 3'b111;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_byte <= '0;
            rx_rdy <= 1'b0;
        end else begin
            rx_state <= rx_nxt;
            rx_m <= RX;
            rx_s <= rx_m;
            rx_d <= rx_s;
            rx_rdy <= rx_tick && rx_bit == 4'd9 && rx_s;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= CW'(BAUD_DIV / 2);
                rx_bit <= '0;
            end else if (rx_tick) begin
                rx_cnt <= CW'(BAUD_DIV);
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit inside {[4'd1:4'd8]}) rx_byte <= {rx_s, rx_byte[7:1]};
            end else begin
                rx_cnt <= rx_cnt - CW'(1);
            end
        end
    end

    assign fr_done = rx_rdy && fr_state == WAIT_LO;

    always_comb begin
        fr_nxt = fr_state;
        fr_nxt = !rx_rdy ? (gap_to ? WAIT_CMD : fr_state) :
                 (fr_state == WAIT_CMD) ? WAIT_HI :
                 (fr_state == WAIT_HI) ? WAIT_LO : WAIT_CMD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_state <= WAIT_CMD;
            cmd_sh <= '0;
            hi_sh <= '0;
            cmd <= '0;
            data <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            fr_state <= fr_nxt;
            if (rx_rdy && fr_state == WAIT_CMD) cmd_sh <= rx_byte;
            if (rx_rdy && fr_state == WAIT_HI) hi_sh <= rx_byte;
            if (fr_done) begin
                cmd <= cmd_sh;
                data <= {hi_sh, rx_byte};
            end
            cmd_rdy <= fr_done ? 1'b1 :
                       (clr_cmd_rdy || (rx_rdy && fr_state == WAIT_CMD)) ? 1'b0 : cmd_rdy;
        end
    end

`ifdef CMD_GAP_TIMEOUT_EN
    localparam int GAP_LIM = GAP_BITS * BAUD_DIV;
    localparam int GW = $clog2(GAP_LIM + 1);
    logic [GW-1:0] gap_cnt;
    assign gap_to = gap_cnt == GW'(GAP_LIM);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gap_cnt <= '0;
        else gap_cnt <= (rx_rdy || fr_state == WAIT_CMD || gap_to) ? '0 :
                        (rx_state == RX_IDLE) ? gap_cnt + GW'(1) : gap_cnt;
    end
`else
    assign gap_to = GAP_BITS < 0;
`endif

    assign tx_tick = tx_state == TX_SHIFT && tx_cnt == '0;
    assign tx_start = tx_state == TX_IDLE && send_resp;
    assign TX = tx_sr[0];

    always_comb begin
        tx_nxt = tx_state;
        tx_nxt = tx_start ? TX_SHIFT : (tx_tick && tx_bit == 4'd9) ? TX_IDLE : tx_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_sr <= '1;
            tx_cnt <= '0;
            tx_bit <= '0;
            resp_sent <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            if (tx_start) begin
                tx_sr <= {1'b1, resp, 1'b0};
                tx_cnt <= CW'(BAUD_DIV - 1);
                tx_bit <= '0;
                resp_sent <= 1'b0;
            end else if (tx_tick) begin
                tx_sr <= {1'b1, tx_sr[9:1]};
                tx_cnt <= CW'(BAUD_DIV - 1);
                tx_bit <= tx_bit + 4'd1;
                if (tx_bit == 4'd9) resp_sent <= 1'b1;
            end else if (tx_state == TX_SHIFT) begin
                tx_cnt <= tx_cnt - CW'(1);
            end
        end
    end
endmodule
